// File: rtl/pipe_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating predictors and perf counters.
// Ports: clock/resetn; IF lookup (pc -> pred_hit/pred_taken/pred_npc, combinational);
//        ID update (upd_*) -> mispredict; flush; clr_stats; br_cnt/mis_cnt counters.
module pipe_btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 32,
  parameter int STAT_W  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_npc,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_is_jump,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_npc,
  output logic              mispredict,
  input  logic              flush,
  input  logic              clr_stats,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] mis_cnt
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [1:0]        cnt_q    [ENTRIES];

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  logic              wr_hit;
  logic [1:0]        wr_cnt, cnt_next;

  // Low two PC bits are always zero for word-aligned instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[1:0], upd_pc[1:0]};

  assign rd_idx = pc[IDX_W+1:2];
  assign rd_tag = pc[ADDR_W-1:IDX_W+2];
  assign wr_idx = upd_pc[IDX_W+1:2];
  assign wr_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup reads registered state only; no bypass from a same-cycle update.
  always_comb begin
    pred_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    pred_taken = pred_hit && cnt_q[rd_idx][1];
    pred_npc   = pred_taken ? target_q[rd_idx] : pc + PC_STEP;
  end

  // A correct direction is not enough when taken: the carried target must match too.
  assign mispredict = upd_en && ((upd_pred_taken != upd_taken) ||
                                 (upd_taken && (upd_pred_npc != upd_target)));

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign wr_cnt = cnt_q[wr_idx];

  always_comb begin
    cnt_next = wr_cnt;
    if (upd_is_jump) begin
      cnt_next = 2'b11;
    end else if (upd_taken) begin
      if (wr_cnt != 2'b11) cnt_next = wr_cnt + 2'b01;
    end else begin
      if (wr_cnt != 2'b00) cnt_next = wr_cnt - 2'b01;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else if (flush) begin
      // Flush wins over a same-cycle update; stale tags/targets are masked by valid.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_en) begin
      if (wr_hit) begin
        cnt_q[wr_idx] <= cnt_next;
        if (upd_taken) target_q[wr_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= upd_target;
        cnt_q[wr_idx]    <= upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (clr_stats) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (upd_en && (br_cnt != STAT_MAX))      br_cnt  <= br_cnt + STAT_ONE;
      if (mispredict && (mis_cnt != STAT_MAX)) mis_cnt <= mis_cnt + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_btb.sv
// Directed bench for pipe_btb: default instance plus a STAT_W=2 instance sharing stimulus.
module tb_pipe_btb;

  logic        clock;
  logic        resetn;
  logic [31:0] pc;
  logic        upd_en, upd_taken, upd_is_jump, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_npc;
  logic        flush, clr_stats;

  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_npc;
  logic [15:0] br_cnt, mis_cnt;

  logic        s_hit, s_taken, s_mis;
  logic [31:0] s_npc;
  logic [1:0]  s_br_cnt, s_mis_cnt;

  int checks = 0;
  int errors = 0;

  pipe_btb u_dut (
    .clock(clock), .resetn(resetn), .pc(pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_is_jump(upd_is_jump), .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
    .mispredict(mispredict), .flush(flush), .clr_stats(clr_stats),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  pipe_btb #(.STAT_W(2)) u_sat (
    .clock(clock), .resetn(resetn), .pc(pc),
    .pred_hit(s_hit), .pred_taken(s_taken), .pred_npc(s_npc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_is_jump(upd_is_jump), .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
    .mispredict(s_mis), .flush(flush), .clr_stats(clr_stats),
    .br_cnt(s_br_cnt), .mis_cnt(s_mis_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] p, input logic tk, input logic [31:0] tgt,
                         input logic jmp, input logic ptk, input logic [31:0] pnpc);
    upd_en = 1'b1; upd_pc = p; upd_taken = tk; upd_target = tgt;
    upd_is_jump = jmp; upd_pred_taken = ptk; upd_pred_npc = pnpc;
  endtask

  task automatic look(input logic [31:0] a, input logic eh, input logic et,
                      input logic [31:0] en, input string nm);
    pc = a;
    #1;
    checks++;
    if (pred_hit !== eh || pred_taken !== et || pred_npc !== en) begin
      errors++;
      $display("FAIL %s: got hit=%b taken=%b npc=%h, want hit=%b taken=%b npc=%h",
               nm, pred_hit, pred_taken, pred_npc, eh, et, en);
    end
  endtask

  task automatic cnts(input logic [15:0] eb, input logic [15:0] em, input string nm);
    checks++;
    if (br_cnt !== eb || mis_cnt !== em) begin
      errors++;
      $display("FAIL %s: got br=%0d mis=%0d, want br=%0d mis=%0d", nm, br_cnt, mis_cnt, eb, em);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; pc = 32'h0040_0000; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_is_jump = 1'b0; upd_pred_taken = 1'b0; upd_pred_npc = '0;
    flush = 1'b0; clr_stats = 1'b0;
    #3;
    look(32'h0040_0000, 1'b0, 1'b0, 32'h0040_0004, "reset_lookup");
    cnts(16'd0, 16'd0, "reset_counts");
    #10 resetn = 1'b1;
    step();
  endtask

  task automatic test_allocate();
    set_upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0040_0014);
    #1;
    checks++;
    if (mispredict !== 1'b1) begin
      errors++; $display("FAIL alloc_mispredict: got %b want 1", mispredict);
    end
    look(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014, "alloc_no_bypass");
    step();
    upd_en = 1'b0;
    look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, "alloc_hit");
    cnts(16'd1, 16'd1, "alloc_counts");
  endtask

  task automatic test_sat_dec();
    set_upd(32'h0040_0010, 1'b0, 32'h0040_0014, 1'b0, 1'b1, 32'h0040_0100);
    step();
    upd_en = 1'b0;
    look(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014, "dec_to_01");
    set_upd(32'h0040_0010, 1'b0, 32'h0040_0014, 1'b0, 1'b0, 32'h0040_0014);
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      errors++; $display("FAIL correct_nt_mispredict: got %b want 0", mispredict);
    end
    step();
    step();
    upd_en = 1'b0;
    look(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014, "dec_sat_00");
    // One taken from 00 reaches only 01: still predicts not-taken.
    set_upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0040_0014);
    step();
    upd_en = 1'b0;
    look(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014, "inc_from_00");
    cnts(16'd5, 16'd3, "dec_counts");
  endtask

  task automatic test_target_mispredict();
    set_upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 1'b1, 32'h0040_0200);
    #1;
    checks++;
    if (mispredict !== 1'b1) begin
      errors++; $display("FAIL target_mispredict: got %b want 1", mispredict);
    end
    upd_en = 1'b0;
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      errors++; $display("FAIL idle_mispredict: got %b want 0", mispredict);
    end
  endtask

  task automatic test_alias();
    set_upd(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b1, 1'b0, 32'h0040_0054);
    step();
    upd_en = 1'b0;
    look(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200, "alias_new_hit");
    look(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014, "alias_evicted");
    // Jump set counter to 11, so one not-taken leaves 10 (still taken).
    set_upd(32'h0040_0050, 1'b0, 32'h0040_0054, 1'b0, 1'b1, 32'h0040_0200);
    step();
    upd_en = 1'b0;
    look(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200, "jump_cnt_11");
    cnts(16'd7, 16'd5, "alias_counts");
    look(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, "pc_wrap");
  endtask

  task automatic test_flush();
    set_upd(32'h0040_0094, 1'b1, 32'h0040_0300, 1'b0, 1'b1, 32'h0040_0300);
    flush = 1'b1;
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      errors++; $display("FAIL flush_upd_mispredict: got %b want 0", mispredict);
    end
    step();
    upd_en = 1'b0; flush = 1'b0;
    look(32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054, "flush_old_entry");
    look(32'h0040_0094, 1'b0, 1'b0, 32'h0040_0098, "flush_no_alloc");
    cnts(16'd8, 16'd5, "flush_counts");
    checks++;
    if (s_mis_cnt !== 2'd3 || s_br_cnt !== 2'd3) begin
      errors++; $display("FAIL small_sat: got br=%0d mis=%0d want 3 3", s_br_cnt, s_mis_cnt);
    end
  endtask

  task automatic test_stats();
    logic [1:0] exp_s [4];
    exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd3; exp_s[3] = 2'd3;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    cnts(16'd0, 16'd0, "clr_counts");
    for (int i = 0; i < 4; i++) begin
      set_upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0040_0014);
      step();
      upd_en = 1'b0;
      checks++;
      if (s_mis_cnt !== exp_s[i]) begin
        errors++; $display("FAIL small_mis_%0d: got %0d want %0d", i, s_mis_cnt, exp_s[i]);
      end
    end
    cnts(16'd4, 16'd4, "stat_counts");
    set_upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0040_0014);
    clr_stats = 1'b1;
    step();
    upd_en = 1'b0; clr_stats = 1'b0;
    cnts(16'd0, 16'd0, "clr_wins");
    checks++;
    if (s_mis_cnt !== 2'd0 || s_br_cnt !== 2'd0) begin
      errors++; $display("FAIL small_clr: got br=%0d mis=%0d want 0 0", s_br_cnt, s_mis_cnt);
    end
  endtask

  task automatic test_async_reset();
    look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, "pre_reset_hit");
    set_upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0040_0014);
    step();
    upd_en = 1'b0;
    #2 resetn = 1'b0;
    look(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014, "async_reset_lookup");
    cnts(16'd0, 16'd0, "async_reset_counts");
    #4 resetn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_sat_dec();
    test_target_mispredict();
    test_alias();
    test_flush();
    test_stats();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
